// File: rtl/pipe_dmem_arbiter.sv
// Data-memory arbiter between the MEM pipeline stage and a debug/loader port.
// The CPU has priority; a starved debug request is forced through with a one-cycle pipeline stall.
module pipe_dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CW       = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [31:0]   dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_ack,
    output logic [31:0]   dbg_rdata,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          grant_dbg,
    output logic [CW-1:0] wait_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_WAIT);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] ZERO_CNT = CW'(0);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] wait_cnt_r;
    logic [CW-1:0] wait_cnt_nxt_s;
    logic [CW-1:0] wait_inc_s;
    logic          dbg_ack_r;
    logic [31:0]   dbg_rdata_r;
    logic          grant_dbg_s;
    logic          mem_we_s;
    logic [31:0]   mem_addr_s;
    logic [31:0]   mem_wdata_s;
    logic          cpu_stall_s;

    assign wait_inc_s = wait_cnt_r + ONE_CNT;

    // RAM ownership: debug only when the CPU is idle, or unconditionally once forced
    always_comb begin
        grant_dbg_s = 1'b0;
        if (reset) begin
            grant_dbg_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_WAIT: grant_dbg_s = dbg_req & ~cpu_req;
                ST_FORCE:         grant_dbg_s = 1'b1;
                ST_ACK:           grant_dbg_s = 1'b0;
                default:          grant_dbg_s = 1'b0;
            endcase
        end
    end

    // Memory port mux; an unowned RAM still sees the CPU address with writes suppressed
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = cpu_addr;
        mem_wdata_s = cpu_wdata;
        if (grant_dbg_s) begin
            mem_we_s    = dbg_we;
            mem_addr_s  = dbg_addr;
            mem_wdata_s = dbg_wdata;
        end else begin
            mem_we_s    = cpu_req & cpu_we & ~reset;
            mem_addr_s  = cpu_addr;
            mem_wdata_s = cpu_wdata;
        end
    end

    // Pipeline freeze only while a forced debug access displaces a real CPU access
    always_comb begin
        cpu_stall_s = 1'b0;
        if (reset) begin
            cpu_stall_s = 1'b0;
        end else begin
            cpu_stall_s = (state_r == ST_FORCE) & cpu_req;
        end
    end

    // Next-state and starvation-counter logic
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (dbg_req && cpu_req) begin
                    wait_cnt_nxt_s = ONE_CNT;
                    state_nxt_s    = (MAX_CNT == ONE_CNT) ? ST_FORCE : ST_WAIT;
                end else if (dbg_req) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!dbg_req) begin
                    state_nxt_s    = ST_IDLE;
                    wait_cnt_nxt_s = ZERO_CNT;
                end else if (!cpu_req) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    wait_cnt_nxt_s = wait_inc_s;
                    state_nxt_s    = (wait_inc_s == MAX_CNT) ? ST_FORCE : ST_WAIT;
                end
            end
            ST_FORCE: begin
                state_nxt_s = ST_ACK;
            end
            ST_ACK: begin
                state_nxt_s    = ST_IDLE;
                wait_cnt_nxt_s = ZERO_CNT;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                wait_cnt_nxt_s = ZERO_CNT;
            end
        endcase
    end

    // State, counter, ack pulse and captured debug read data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= ZERO_CNT;
            dbg_ack_r   <= 1'b0;
            dbg_rdata_r <= 32'h0000_0000;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            dbg_ack_r  <= (state_nxt_s == ST_ACK);
            if (grant_dbg_s) begin
                dbg_rdata_r <= mem_rdata;
            end else begin
                dbg_rdata_r <= dbg_rdata_r;
            end
        end
    end

    assign cpu_rdata = mem_rdata;
    assign cpu_stall = cpu_stall_s;
    assign dbg_ack   = dbg_ack_r;
    assign dbg_rdata = dbg_rdata_r;
    assign mem_we    = mem_we_s;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign grant_dbg = grant_dbg_s;
    assign wait_cnt  = wait_cnt_r;

    pipe_dmem_arbiter_chk #(
        .MAX_WAIT (MAX_WAIT),
        .CW       (CW)
    ) u_chk (
        .clock     (clock),
        .reset     (reset),
        .cpu_stall (cpu_stall_s),
        .grant_dbg (grant_dbg_s),
        .dbg_ack   (dbg_ack_r),
        .wait_cnt  (wait_cnt_r)
    );

endmodule

// Protocol invariants of the arbiter, kept apart from the datapath.
module pipe_dmem_arbiter_chk #(
    parameter int MAX_WAIT = 4,
    parameter int CW       = 4
) (
    input logic          clock,
    input logic          reset,
    input logic          cpu_stall,
    input logic          grant_dbg,
    input logic          dbg_ack,
    input logic [CW-1:0] wait_cnt
);

    a_cnt_bound: assert property (@(posedge clock) disable iff (reset) wait_cnt <= CW'(MAX_WAIT));
    a_stall_grant: assert property (@(posedge clock) disable iff (reset) cpu_stall |-> grant_dbg);
    a_ack_no_grant: assert property (@(posedge clock) disable iff (reset) dbg_ack |-> !grant_dbg);
    a_ack_pulse: assert property (@(posedge clock) disable iff (reset) dbg_ack |=> !dbg_ack);
    a_stall_once: assert property (@(posedge clock) disable iff (reset) cpu_stall |=> !cpu_stall);

endmodule

// File: tb/tb_pipe_dmem_arbiter.sv
// Directed bench for pipe_dmem_arbiter: a cycle-by-cycle vector table plus
// hand-written reset-in-FORCE / reset-in-ACK sequences, against a small RAM model.
module tb_pipe_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        grant_dbg;
    logic [3:0]  wait_cnt;

    logic [31:0] ram [0:63];
    logic        ram_clr;

    int n_vec = 0;
    int n_err = 0;

    pipe_dmem_arbiter #(.MAX_WAIT(4), .CW(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .grant_dbg (grant_dbg),
        .wait_cnt  (wait_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: asynchronous read, write on the rising clock edge
    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clock) begin
        if (ram_clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
        end else if (mem_we) begin
            ram[mem_addr[7:2]] <= mem_wdata;
        end
    end

    typedef struct {
        logic        rst;
        logic        c_req;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wd;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wd;
        logic        e_gnt;
        logic        e_stall;
        logic        e_ack;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_wait;
        logic [31:0] e_drd;
        logic        e_chk;
        logic [31:0] e_crd;
    } vec_t;

    vec_t tbl [32];

    task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL v%0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset     = v.rst;
        cpu_req   = v.c_req;
        cpu_we    = v.c_we;
        cpu_addr  = v.c_addr;
        cpu_wdata = v.c_wd;
        dbg_req   = v.d_req;
        dbg_we    = v.d_we;
        dbg_addr  = v.d_addr;
        dbg_wdata = v.d_wd;
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        chk(idx, "grant_dbg", {31'd0, grant_dbg}, {31'd0, v.e_gnt});
        chk(idx, "cpu_stall", {31'd0, cpu_stall}, {31'd0, v.e_stall});
        chk(idx, "dbg_ack", {31'd0, dbg_ack}, {31'd0, v.e_ack});
        chk(idx, "mem_we", {31'd0, mem_we}, {31'd0, v.e_we});
        chk(idx, "mem_addr", mem_addr, v.e_addr);
        chk(idx, "mem_wdata", mem_wdata, v.e_gnt ? v.d_wd : v.c_wd);
        chk(idx, "wait_cnt", {28'd0, wait_cnt}, {28'd0, v.e_wait});
        chk(idx, "dbg_rdata", dbg_rdata, v.e_drd);
        if (v.e_chk) chk(idx, "cpu_rdata", cpu_rdata, v.e_crd);
    endtask

    initial begin
        // rst c_req c_we c_addr c_wd | d_req d_we d_addr d_wd | gnt stall ack we addr wait drd chk crd
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 4'd0, 32'h0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 4'd0, 32'h0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 4'd0, 32'h0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 4'd0, 32'h0, 1'b1, 32'hDEADBEEF};
        // starvation: CPU busy every cycle, debug read forced in cycle 4
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h44, 32'h11111111, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 4'd0, 32'h0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 4'd1, 32'h0, 1'b1, 32'h11111111};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 4'd2, 32'h0, 1'b1, 32'hDEADBEEF};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 4'd3, 32'h0, 1'b1, 32'hDEADBEEF};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h48, 32'h22222222, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 4'd4, 32'h0, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h48, 32'h22222222, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h48, 4'd4, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h4C, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4C, 4'd0, 32'hDEADBEEF, 1'b0, 32'h0};
        // CPU gap lets the debug read through in cycle 2 without a stall
        tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h48, 4'd0, 32'hDEADBEEF, 1'b1, 32'h22222222};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h48, 4'd1, 32'hDEADBEEF, 1'b1, 32'h22222222};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h48, 4'd2, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 4'd2, 32'h22222222, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 4'd0, 32'h22222222, 1'b0, 32'h0};
        // abandoned request in WAIT
        tbl[16] = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 4'd0, 32'h22222222, 1'b1, 32'hDEADBEEF};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 4'd1, 32'h22222222, 1'b1, 32'hDEADBEEF};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 4'd2, 32'h22222222, 1'b1, 32'hDEADBEEF};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 4'd0, 32'h22222222, 1'b0, 32'h0};
        // request held through ACK: no grant in ACK, second grant right after
        tbl[20] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b1, 32'h50, 32'h33333333, 1'b1, 1'b0, 1'b0, 1'b1, 32'h50, 4'd0, 32'h22222222, 1'b0, 32'h0};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 4'd0, 32'h0, 1'b0, 32'h0};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h50, 4'd0, 32'h0, 1'b0, 32'h0};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 4'd0, 32'h33333333, 1'b0, 32'h0};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 4'd0, 32'h33333333, 1'b0, 32'h0};
        // FORCE reached while the CPU happens to be idle: no stall
        for (int k = 0; k < 4; k++)
            tbl[25+k] = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 4'(k), 32'h33333333, 1'b1, 32'hDEADBEEF};
        tbl[29] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 4'd4, 32'h33333333, 1'b0, 32'h0};
        tbl[30] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 4'd4, 32'h11111111, 1'b0, 32'h0};
        tbl[31] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 4'd0, 32'h11111111, 1'b0, 32'h0};

        reset = 1'b1; ram_clr = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
        repeat (2) @(posedge clock);
        #1 ram_clr = 1'b0;

        for (int i = 0; i < 32; i++) begin
            @(posedge clock);
            #1 drive(tbl[i]);
            @(negedge clock);
            check_vec(i, tbl[i]);
        end

        // reset asserted mid-cycle in FORCE: the forced write is abandoned
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h60;
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h60; dbg_wdata = 32'h55555555;
            @(negedge clock);
            chk(100 + k, "h_wait_cnt", {28'd0, wait_cnt}, 32'(k));
        end
        @(posedge clock);
        #1;
        chk(110, "h_force_grant", {31'd0, grant_dbg}, 32'd1);
        chk(110, "h_force_stall", {31'd0, cpu_stall}, 32'd1);
        chk(110, "h_force_we", {31'd0, mem_we}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk(111, "h_rst_grant", {31'd0, grant_dbg}, 32'd0);
        chk(111, "h_rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk(111, "h_rst_we", {31'd0, mem_we}, 32'd0);
        chk(111, "h_rst_wait", {28'd0, wait_cnt}, 32'd0);
        chk(111, "h_rst_ack", {31'd0, dbg_ack}, 32'd0);
        chk(111, "h_rst_drd", dbg_rdata, 32'h0);

        // retry after reset completes normally
        @(posedge clock);
        #1 reset = 1'b0; cpu_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h50;
        @(negedge clock);
        chk(112, "h_retry_grant", {31'd0, grant_dbg}, 32'd1);
        chk(112, "h_retry_noack", {31'd0, dbg_ack}, 32'd0);
        @(posedge clock);
        #1 dbg_req = 1'b0;
        @(negedge clock);
        chk(113, "h_retry_ack", {31'd0, dbg_ack}, 32'd1);
        chk(113, "h_retry_drd", dbg_rdata, 32'h33333333);

        // reset asserted mid-cycle during ACK kills the pulse at once
        @(posedge clock);
        #1 dbg_req = 1'b1; dbg_addr = 32'h44;
        @(negedge clock);
        chk(114, "h_g2_grant", {31'd0, grant_dbg}, 32'd1);
        @(posedge clock);
        #1 dbg_req = 1'b0;
        #2;
        chk(115, "h_ack_pre", {31'd0, dbg_ack}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk(115, "h_ack_rst", {31'd0, dbg_ack}, 32'd0);
        chk(115, "h_ack_rst_drd", dbg_rdata, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h60;
        @(negedge clock);
        chk(116, "h_post_ack", {31'd0, dbg_ack}, 32'd0);
        chk(116, "h_post_grant", {31'd0, grant_dbg}, 32'd0);
        chk(116, "h_no_force_wr", cpu_rdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
